// File: rtl/riscv_defines.sv
// ----------------------------------------------------------------------------
// riscv_defines
// Shared type definitions for the DIFT (dynamic information flow tracking)
// trap path.
//   dift_trap_t       : violation class reported by dift_tag_check
//   dift_trap_state_t : state encoding of the dift_trap_ctrl capture FSM
// ----------------------------------------------------------------------------
package riscv_defines;

   typedef enum logic [2:0] {
      DIFT_TRAP_TYPE_NONE = 3'd0,
      DIFT_TRAP_TYPE_LOAD = 3'd1,
      DIFT_TRAP_TYPE_STOR = 3'd2,
      DIFT_TRAP_TYPE_JALR = 3'd3,
      DIFT_TRAP_TYPE_BRCH = 3'd4,
      DIFT_TRAP_TYPE_EXEC = 3'd5
   } dift_trap_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HELD = 2'd2
   } dift_trap_state_t;

endpackage

// File: rtl/dift_trap_ctrl_if.sv
// ----------------------------------------------------------------------------
// dift_trap_ctrl_if
// Signal bundle between the pipeline / controller and dift_trap_ctrl.
//   slave  modport : view of dift_trap_ctrl (violation + handshake inputs,
//                    trap request / captured record / counter outputs)
//   master modport : view of the pipeline/controller side
// Parameter CNT_WIDTH must match the dift_trap_ctrl instance it connects to.
// ----------------------------------------------------------------------------
interface dift_trap_ctrl_if #(
   parameter int CNT_WIDTH = 16
) ();

   logic                      trap_i;
   riscv_defines::dift_trap_t trap_type_i;
   logic                      id_valid_i;
   logic [31:0]               pc_id_i;
   logic                      trap_ack_i;
   logic                      clr_i;
   logic                      trap_req_o;
   riscv_defines::dift_trap_t trap_cause_o;
   logic [31:0]               trap_pc_o;
   logic [CNT_WIDTH-1:0]      viol_cnt_o;

   modport slave (
      input  trap_i, trap_type_i, id_valid_i, pc_id_i, trap_ack_i, clr_i,
      output trap_req_o, trap_cause_o, trap_pc_o, viol_cnt_o
   );

   modport master (
      output trap_i, trap_type_i, id_valid_i, pc_id_i, trap_ack_i, clr_i,
      input  trap_req_o, trap_cause_o, trap_pc_o, viol_cnt_o
   );

endinterface

// File: rtl/dift_trap_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// dift_sat_counter
// Saturating up-counter: counts inc pulses, holds at all-ones (never wraps).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears count
//   inc   : increment request for this cycle
//   count : current count (WIDTH bits)
// ----------------------------------------------------------------------------
module dift_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
         count_reg <= count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/dift_trap_ctrl.sv
// ----------------------------------------------------------------------------
// dift_trap_ctrl
// Captures the first qualified DIFT tag-check violation, raises a registered
// trap request to the core controller, and freezes the faulting record
// (cause + PC) until software releases it.
//   IDLE --violation--> REQ --trap_ack_i--> HELD --clr_i--> IDLE
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dift_trap_ctrl_if.slave
//           in : trap_i, trap_type_i, id_valid_i, pc_id_i, trap_ack_i, clr_i
//           out: trap_req_o, trap_cause_o, trap_pc_o, viol_cnt_o
// Parameter CNT_WIDTH : width of the violation counter.
// Configuration macro DIFT_TRAP_COUNTER_EN: when defined, viol_cnt_o is a
// saturating count of qualified violations; otherwise it is tied to zero and
// no counter registers exist.
// ----------------------------------------------------------------------------
module dift_trap_ctrl
   import riscv_defines::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   dift_trap_ctrl_if.slave bus
);

   dift_trap_state_t state_reg, state_next;
   dift_trap_t       cause_reg;
   logic [31:0]      pc_reg;
   logic             qual_viol;
   logic             capture;

   // trap_i only means something for an instruction that actually completes.
   assign qual_viol = bus.trap_i & bus.id_valid_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture happens only on the IDLE->REQ transition, so a violation that
   // coincides with a clear in HELD is counted but never recorded.
   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (qual_viol) begin
               state_next = REQ;
               capture    = 1'b1;
            end
         end
         REQ: begin
            if (bus.trap_ack_i) begin
               state_next = HELD;
            end
         end
         HELD: begin
            if (bus.clr_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_reg <= DIFT_TRAP_TYPE_NONE;
         pc_reg    <= 32'h0;
      end else if (capture) begin
         cause_reg <= bus.trap_type_i;
         pc_reg    <= bus.pc_id_i;
      end
   end

   // Request is a pure decode of the state register, hence registered.
   assign bus.trap_req_o   = (state_reg == REQ);
   assign bus.trap_cause_o = cause_reg;
   assign bus.trap_pc_o    = pc_reg;

`ifdef DIFT_TRAP_COUNTER_EN
   logic [CNT_WIDTH-1:0] viol_cnt;

   dift_sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_viol_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (qual_viol),
      .count (viol_cnt)
   );

   assign bus.viol_cnt_o = viol_cnt;
`else
   assign bus.viol_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_dift_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dift_trap_ctrl
// Directed self-checking bench for dift_trap_ctrl (CNT_WIDTH=4) plus a direct
// check of dift_sat_counter. Counter expectations follow DIFT_TRAP_COUNTER_EN.
// ----------------------------------------------------------------------------
module tb_dift_trap_ctrl;
   import riscv_defines::*;

   localparam int CW = 4;

   logic clk;
   logic rst_n;
   logic       sc_inc;
   logic [2:0] sc_count;

   int n_checks;
   int n_fail;

   dift_trap_ctrl_if #(.CNT_WIDTH(CW)) bus ();

   dift_trap_ctrl #(
      .CNT_WIDTH (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   dift_sat_counter #(
      .WIDTH (3)
   ) u_sc (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sc_inc),
      .count (sc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected viol_cnt_o after n qualified violations since reset.
   function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef DIFT_TRAP_COUNTER_EN
      if (n > 15) return 4'd15;
      return 4'(n);
`else
      if (n < 0) return 4'd1;
      return 4'd0;
`endif
   endfunction

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_viol(input logic t, input logic v, input dift_trap_t ty,
                           input logic [31:0] pc);
      bus.trap_i      = t;
      bus.id_valid_i  = v;
      bus.trap_type_i = ty;
      bus.pc_id_i     = pc;
   endtask

   task automatic check_out(input string name, input logic req,
                            input dift_trap_t cause, input logic [31:0] pc,
                            input int cnt);
      n_checks++;
      if (bus.trap_req_o !== req) begin
         n_fail++;
         $display("FAIL %s trap_req_o: got %0b expected %0b", name, bus.trap_req_o, req);
      end
      n_checks++;
      if (bus.trap_cause_o !== cause) begin
         n_fail++;
         $display("FAIL %s trap_cause_o: got %0d expected %0d", name, bus.trap_cause_o, cause);
      end
      n_checks++;
      if (bus.trap_pc_o !== pc) begin
         n_fail++;
         $display("FAIL %s trap_pc_o: got 0x%08h expected 0x%08h", name, bus.trap_pc_o, pc);
      end
      n_checks++;
      if (bus.viol_cnt_o !== exp_cnt(cnt)) begin
         n_fail++;
         $display("FAIL %s viol_cnt_o: got %0d expected %0d", name, bus.viol_cnt_o, exp_cnt(cnt));
      end
      $display("[%0t] %s: req=%0b cause=%0d pc=0x%08h cnt=%0d", $time, name,
               bus.trap_req_o, bus.trap_cause_o, bus.trap_pc_o, bus.viol_cnt_o);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check_out("reset", 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 0);
      rst_n = 1'b1;
      tick();
      check_out("post_reset_idle", 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 0);
   endtask

   task automatic test_sat_counter();
      sc_inc = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (sc_count !== 3'd3) begin
         n_fail++;
         $display("FAIL sat_counter_3: got %0d expected 3", sc_count);
      end
      for (int i = 0; i < 7; i++) tick();
      sc_inc = 1'b0;
      tick();
      n_checks++;
      if (sc_count !== 3'd7) begin
         n_fail++;
         $display("FAIL sat_counter_sat: got %0d expected 7", sc_count);
      end
      $display("[%0t] sat_counter: count=%0d", $time, sc_count);
   endtask

   task automatic test_unqualified();
      set_viol(1'b1, 1'b0, DIFT_TRAP_TYPE_STOR, 32'h0000_0500);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (bus.trap_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL unqualified_req cycle %0d: got %0b expected 0", i, bus.trap_req_o);
         end
      end
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      // Also an ack and a clear in IDLE must do nothing.
      bus.trap_ack_i = 1'b1;
      bus.clr_i      = 1'b1;
      tick();
      bus.trap_ack_i = 1'b0;
      bus.clr_i      = 1'b0;
      check_out("unqualified", 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 0);
   endtask

   task automatic test_capture();
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_1040);
      tick();
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      check_out("capture", 1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 1);
      tick();
      tick();
      check_out("req_hold", 1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 1);
   endtask

   task automatic test_req_second_and_ack();
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_LOAD, 32'h0000_2000);
      tick();
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      check_out("req_second_viol", 1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 2);
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      check_out("req_clr_ignored", 1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 2);
      bus.trap_ack_i = 1'b1;
      tick();
      bus.trap_ack_i = 1'b0;
      check_out("ack_to_held", 1'b0, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 2);
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_EXEC, 32'h0000_2400);
      tick();
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      check_out("held_viol", 1'b0, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 3);
   endtask

   task automatic test_clear_with_violation();
      bus.clr_i = 1'b1;
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_JALR, 32'h0000_3000);
      tick();
      bus.clr_i = 1'b0;
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      check_out("clr_plus_viol", 1'b0, DIFT_TRAP_TYPE_STOR, 32'h0000_1040, 4);
      // Back in IDLE: a fresh violation must be captured.
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_JALR, 32'h0000_3004);
      tick();
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      check_out("recapture", 1'b1, DIFT_TRAP_TYPE_JALR, 32'h0000_3004, 5);
   endtask

   task automatic test_none_type();
      bus.trap_ack_i = 1'b1;
      tick();
      bus.trap_ack_i = 1'b0;
      bus.clr_i      = 1'b1;
      tick();
      bus.clr_i      = 1'b0;
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_NONE, 32'h0000_0044);
      tick();
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      check_out("none_type", 1'b1, DIFT_TRAP_TYPE_NONE, 32'h0000_0044, 6);
   endtask

   task automatic test_saturate();
      set_viol(1'b1, 1'b1, DIFT_TRAP_TYPE_BRCH, 32'h0000_5000);
      for (int i = 0; i < 20; i++) tick();
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);
      tick();
      check_out("saturate", 1'b1, DIFT_TRAP_TYPE_NONE, 32'h0000_0044, 26);
   endtask

   task automatic test_async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 0);
      #1;
      rst_n = 1'b1;
      tick();
      check_out("after_async_reset", 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 0);
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      sc_inc         = 1'b0;
      bus.trap_ack_i = 1'b0;
      bus.clr_i      = 1'b0;
      set_viol(1'b0, 1'b0, DIFT_TRAP_TYPE_NONE, 32'h0);

      test_reset();
      test_sat_counter();
      test_unqualified();
      test_capture();
      test_req_second_and_ack();
      test_clear_with_violation();
      test_none_type();
      test_saturate();
      test_async_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dift_trap_ctrl.md
DIFT_TRAP_CTRL -- requirements
Module: dift_trap_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the violation counter.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port trap_i  input  1  tag-check violation flag from dift_tag_check.
REQ-005 SHALL have port trap_type_i  input  dift_trap_t  violation class from dift_tag_check.
REQ-006 SHALL have port id_valid_i  input  1  ID-stage instruction completes this cycle; qualifies trap_i.
REQ-007 SHALL have port pc_id_i  input  32  PC of the ID-stage instruction.
REQ-008 SHALL have port trap_ack_i  input  1  controller has accepted the trap and entered the handler.
REQ-009 SHALL have port clr_i  input  1  software clear (CSR write) releasing the captured record.
REQ-010 SHALL have port trap_req_o  output  1  trap request to controller.
REQ-011 SHALL have port trap_cause_o  output  dift_trap_t  captured violation class.
REQ-012 SHALL have port trap_pc_o  output  32  captured faulting PC.
REQ-013 SHALL have port viol_cnt_o  output  CNT_WIDTH  saturating count of qualified violations.

Function
REQ-014 A violation SHALL be qualified only when trap_i=1 and id_valid_i=1 in the same cycle.
REQ-015 FSM states SHALL be IDLE, REQ, HELD.
REQ-016 IDLE: qualified violation in cycle N -> REQ at N+1; trap_cause_o/trap_pc_o capture trap_type_i/pc_id_i of cycle N; trap_req_o=1 from N+1 (one-cycle latency, registered).
REQ-017 REQ: trap_req_o SHALL stay 1 until trap_ack_i=1; on ack -> HELD, trap_req_o=0 next cycle.
REQ-018 HELD: trap_req_o=0; captured record SHALL stay frozen; clr_i=1 -> IDLE next cycle.
REQ-019 In REQ and HELD, further qualified violations SHALL NOT overwrite the record and SHALL NOT re-raise trap_req_o.
REQ-020 clr_i in IDLE or REQ SHALL be ignored.
REQ-021 Qualified violation and clr_i in same HELD cycle: clear wins (-> IDLE), violation counted but not captured.
REQ-022 trap_ack_i outside REQ SHALL be ignored.
REQ-023 viol_cnt_o SHALL increment by 1 per qualified violation in every state, saturating at 2^CNT_WIDTH-1 (no wrap); clr_i does not reset it.
REQ-024 trap_type_i=DIFT_TRAP_TYPE_NONE with trap_i=1 SHALL still be captured/counted as given.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, trap_req_o=0, trap_cause_o=DIFT_TRAP_TYPE_NONE, trap_pc_o=0, viol_cnt_o=0, including mid-REQ/HELD.

Configuration
REQ-026 Macro DIFT_TRAP_COUNTER_EN defined: counter implemented per REQ-023.
REQ-027 Macro undefined: no counter registers; viol_cnt_o tied to 0; all other behaviour unchanged.

Structure
REQ-028 dift_trap_t and DIFT_TRAP_TYPE_* SHALL come from riscv_defines; new dift_trap_state_t (IDLE/REQ/HELD) SHALL be added there.
REQ-029 Saturating counter SHALL be sub-module dift_sat_counter (parameter WIDTH; inc, count).

Verification
REQ-030 IDLE, trap_i=1, id_valid_i=1, type=STOR, pc=0x0000_1040 at N -> trap_req_o=1 at N+1, cause=STOR, pc_o=0x1040, cnt=1.
REQ-031 trap_i=1, id_valid_i=0 for 5 cycles -> trap_req_o stays 0, cnt=0.
REQ-032 In REQ, second violation (LOAD, 0x2000) then ack -> cause/pc remain first record, HELD, cnt=2.
REQ-033 HELD, clr_i=1 with qualified JALR violation same cycle -> IDLE next cycle, trap_req_o=0, record unchanged, cnt incremented.
REQ-034 CNT_WIDTH=4, 20 qualified violations -> viol_cnt_o=15; macro undefined -> 0.
REQ-035 rst_n low mid-REQ (asynchronous to clk) -> trap_req_o=0 immediately, all outputs at reset values.
